// File: rtl/ct_spsram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ct_spsram_ctrl_pkg
// Brief    : Shared types and default sizes for the 1024x64 SRAM front-end.
// Revision : 1.0 - initial release
// ============================================================================
package ct_spsram_ctrl_pkg;

    localparam int c_DEF_ADDR_WIDTH = 10;
    localparam int c_DEF_DATA_WIDTH = 64;
    localparam int c_DEF_RSP_DEPTH  = 2;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ct_spsram_1024x64_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ct_spsram_1024x64_ctrl_if
// Brief    : Request/response stream bundle between requester and controller.
// Revision : 1.0 - initial release
// ============================================================================
interface ct_spsram_1024x64_ctrl_if #(
    parameter int ADDR_WIDTH = ct_spsram_ctrl_pkg::c_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = ct_spsram_ctrl_pkg::c_DEF_DATA_WIDTH
);

    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] req_wmask;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata
    );

endinterface
`default_nettype wire

// File: rtl/ct_spsram_ctrl_rspfifo.sv
`default_nettype none
// ============================================================================
// Module   : ct_spsram_ctrl_rspfifo
// Brief    : Small synchronous FIFO holding SRAM read data until consumed.
// Revision : 1.0 - initial release
// ============================================================================
module ct_spsram_ctrl_rspfifo
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int DEPTH = c_DEF_RSP_DEPTH,
    parameter int WIDTH = c_DEF_DATA_WIDTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_pop,
    output logic      [CNT_W-1:0] o_count,
    output logic      [WIDTH-1:0] o_head
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(i_push) - CNT_W'(i_pop);
        if (i_push) begin
            mem_d[wr_ptr_q] = i_wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (i_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/ct_spsram_1024x64_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ct_spsram_1024x64_ctrl
// Brief    : Clears the SRAM after reset, then maps req stream to macro pins.
// Revision : 1.0 - initial release
// ============================================================================
module ct_spsram_1024x64_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int RSP_DEPTH  = c_DEF_RSP_DEPTH
) (
    input  wire logic                  CLK,
    input  wire logic                  RST,
    ct_spsram_1024x64_ctrl_if.slave    bus,
    output logic                       init_done,
    output logic      [ADDR_WIDTH-1:0] A,
    output logic                       CEN,
    output logic                       GWEN,
    output logic      [DATA_WIDTH-1:0] WEN,
    output logic      [DATA_WIDTH-1:0] D,
    input  wire logic [DATA_WIDTH-1:0] Q
);

    localparam int c_CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int c_OCC_W = c_CNT_W + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;

    logic [c_CNT_W-1:0]    w_fifo_count;
    logic [DATA_WIDTH-1:0] w_fifo_head;
    logic [c_OCC_W-1:0]    w_occ;
    logic                  w_rsp_vld;
    logic                  w_pop;
    logic                  w_req_rdy;
    logic                  w_accept;

    // Credits count the in-flight read plus buffered entries; a same-cycle pop
    // frees one so a continuously drained stream issues every cycle.
    assign w_rsp_vld = ~RST & (w_fifo_count != '0);
    assign w_pop     = w_rsp_vld & bus.rsp_rdy;
    assign w_occ     = c_OCC_W'(w_fifo_count) + c_OCC_W'(inflight_q) - c_OCC_W'(w_pop);
    assign w_req_rdy = ~RST & (state_q == RUN) & (w_occ < c_OCC_W'(RSP_DEPTH));
    assign w_accept  = bus.req_vld & w_req_rdy;

    assign bus.req_rdy   = w_req_rdy;
    assign bus.rsp_vld   = w_rsp_vld;
    assign bus.rsp_rdata = RST ? '0 : w_fifo_head;
    assign init_done     = ~RST & (state_q == RUN);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        inflight_d = 1'b0;
        CEN        = 1'b1;
        GWEN       = 1'b1;
        WEN        = '1;
        A          = '0;
        D          = '0;
        if (!RST) begin
            case (state_q)
                INIT: begin
                    CEN   = 1'b0;
                    GWEN  = 1'b0;
                    WEN   = '0;
                    A     = cnt_q;
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == '1) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        CEN = 1'b0;
                        A   = bus.req_addr;
                        if (bus.req_wr) begin
                            GWEN = 1'b0;
                            WEN  = ~bus.req_wmask;
                            D    = bus.req_wdata;
                        end else begin
                            inflight_d = 1'b1;
                        end
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
        end
    end

    ct_spsram_ctrl_rspfifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH),
        .CNT_W (c_CNT_W)
    ) u_rspfifo (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (inflight_q),
        .i_wdata (Q),
        .i_pop   (w_pop),
        .o_count (w_fifo_count),
        .o_head  (w_fifo_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_ct_spsram_1024x64_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_spsram_1024x64_ctrl
// Brief    : Randomised bench with a word-array reference and response queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ct_spsram_1024x64_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int DEPTH = 2;
    localparam int WORDS = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          init_done;
    logic [AW-1:0] A;
    logic          CEN;
    logic          GWEN;
    logic [DW-1:0] WEN;
    logic [DW-1:0] D;
    logic [DW-1:0] Q;

    ct_spsram_1024x64_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ct_spsram_1024x64_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .init_done (init_done),
        .A         (A),
        .CEN       (CEN),
        .GWEN      (GWEN),
        .WEN       (WEN),
        .D         (D),
        .Q         (Q)
    );

    always #5 CLK = ~CLK;

    // Macro stand-in: contents scrambled while reset is held.
    logic [DW-1:0] sram [WORDS];
    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < WORDS; i++) sram[i] <= {$urandom(), $urandom()};
        end else if (!CEN) begin
            if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
            else       Q <= sram[A];
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    logic [DW-1:0] ref_mem [WORDS];
    rsp_t          exp_q [$];
    int            cyc   = 0;
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] last_pop;
    bit            last_dut_acc;
    bit            last_dut_pop;
    logic [AW-1:0] bp_addr [4];

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_idle();
        bus.req_vld   = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
    endtask

    task automatic apply_reset();
        set_idle();
        bus.rsp_rdy = 1'b0;
        RST = 1'b1;
        @(negedge CLK); #1;
        check_val("rst_ctl", 64'({CEN, GWEN, bus.req_rdy, bus.rsp_vld, init_done}), 64'(5'b11000));
        check_val("rst_wen", WEN, '1);
        check_val("rst_a", 64'(A), 64'(0));
        check_val("rst_d", D, 64'(0));
        check_val("rst_rdata", bus.rsp_rdata, 64'(0));
        @(negedge CLK); #1;
        RST = 1'b0;
        #1;
        exp_q.delete();
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            check_val("sweep_ctl", 64'({CEN, GWEN, bus.req_rdy, init_done, bus.rsp_vld}), 64'(5'b00000));
            check_val("sweep_addr", 64'(A), 64'(i));
            check_val("sweep_wen", WEN, 64'(0));
            check_val("sweep_d", D, 64'(0));
            @(negedge CLK); #1;
        end
    endtask

    // One clock of stimulus; expectations come from the word array and queue.
    task automatic do_cycle(input bit vld, input bit wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                            input bit rr, output bit acc);
        bit exp_vld;
        bit pop;
        bit exp_rdy;
        bus.req_vld   = vld;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_wmask = wm;
        bus.rsp_rdy   = rr;
        #1;
        exp_vld = (exp_q.size() != 0) && (exp_q[0].due <= cyc);
        pop     = exp_vld && rr;
        exp_rdy = (exp_q.size() - int'(pop)) < DEPTH;
        acc     = vld && exp_rdy;
        last_dut_acc = vld && bus.req_rdy;
        last_dut_pop = bus.rsp_vld && rr;
        if (last_dut_pop) last_pop = bus.rsp_rdata;
        check_val("init_done", 64'(init_done), 64'(1));
        check_val("req_rdy", 64'(bus.req_rdy), 64'(exp_rdy));
        check_val("rsp_vld", 64'(bus.rsp_vld), 64'(exp_vld));
        if (exp_vld) check_val("rsp_rdata", bus.rsp_rdata, exp_q[0].data);
        check_val("cen", 64'(CEN), 64'(!acc));
        check_val("gwen", 64'(GWEN), 64'(!(acc && wr)));
        check_val("a", 64'(A), acc ? 64'(addr) : 64'(0));
        check_val("wen", WEN, (acc && wr) ? ~wm : {DW{1'b1}});
        check_val("d", D, (acc && wr) ? wd : 64'(0));
        if (pop) void'(exp_q.pop_front());
        if (acc && wr) ref_mem[addr] = (ref_mem[addr] & ~wm) | (wd & wm);
        else if (acc)  exp_q.push_back('{data: ref_mem[addr], due: cyc + 2});
        cyc++;
        @(negedge CLK); #1;
    endtask

    task automatic idle(input int n, input bit rr);
        bit acc;
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, '0, '0, '0, rr, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        bit            acc;
        bit            pend;
        bit            r_wr;
        logic [AW-1:0] r_addr;
        logic [DW-1:0] r_wd;
        logic [DW-1:0] r_wm;
        int            idx;
        int            n_acc;
        int            n_pop;

        bp_addr[0] = 10'h155;
        bp_addr[1] = 10'h3FF;
        bp_addr[2] = 10'h010;
        bp_addr[3] = 10'h155;
        last_pop   = '0;

        apply_reset();
        sweep(WORDS);
        check_val("init_done_1025", 64'(init_done), 64'(1));

        // Cleared top word, then full and masked writes with read-after-write.
        do_cycle(1'b1, 1'b0, 10'h3FF, '0, '0, 1'b1, acc);
        idle(3, 1'b1);
        check_val("rd_3ff", last_pop, 64'(0));
        do_cycle(1'b1, 1'b1, 10'h155, 64'hDEADBEEF_CAFEF00D, '1, 1'b1, acc);
        do_cycle(1'b1, 1'b0, 10'h155, '0, '0, 1'b1, acc);
        idle(3, 1'b1);
        check_val("rd_155_full", last_pop, 64'hDEADBEEF_CAFEF00D);
        do_cycle(1'b1, 1'b1, 10'h155, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b1, acc);
        do_cycle(1'b1, 1'b0, 10'h155, '0, '0, 1'b1, acc);
        idle(3, 1'b1);
        check_val("rd_155_mask", last_pop, 64'hDEADBEEF_FFFFFFFF);

        // Four reads offered against a stalled consumer.
        idx = 0; n_acc = 0; n_pop = 0;
        for (int i = 0; i < 6; i++) begin
            do_cycle(idx < 4, 1'b0, bp_addr[idx % 4], '0, '0, 1'b0, acc);
            if (acc) idx++;
            n_acc += int'(last_dut_acc);
        end
        check_val("bp_accepts", 64'(n_acc), 64'(2));
        for (int i = 0; i < 12; i++) begin
            do_cycle(idx < 4, 1'b0, bp_addr[idx % 4], '0, '0, 1'b1, acc);
            if (acc) idx++;
            n_pop += int'(last_dut_pop);
        end
        check_val("bp_pops", 64'(n_pop), 64'(4));

        // Back-to-back reads with the consumer always ready.
        n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            do_cycle(1'b1, 1'b0, AW'(k), '0, '0, 1'b1, acc);
            n_acc += int'(last_dut_acc);
        end
        check_val("burst_accepts", 64'(n_acc), 64'(8));
        idle(4, 1'b1);

        pend = 1'b0; r_wr = 1'b0; r_addr = '0; r_wd = '0; r_wm = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                pend   = 1'b1;
                r_wr   = ($urandom_range(0, 2) == 0);
                r_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 15));
                r_wd   = {$urandom(), $urandom()};
                r_wm   = ($urandom_range(0, 1) == 0) ? {DW{1'b1}} : {$urandom(), $urandom()};
            end
            do_cycle(pend, r_wr, r_addr, r_wd, r_wm, $urandom_range(0, 3) != 0, acc);
            if (acc) pend = 1'b0;
        end
        idle(4, 1'b1);

        // Reset while two responses sit in the FIFO.
        do_cycle(1'b1, 1'b0, 10'h155, '0, '0, 1'b0, acc);
        do_cycle(1'b1, 1'b0, 10'h010, '0, '0, 1'b0, acc);
        idle(2, 1'b0);
        apply_reset();
        sweep(WORDS);
        check_val("init_done_after_rst", 64'(init_done), 64'(1));
        idle(2, 1'b1);

        // Reset in the middle of the sweep.
        apply_reset();
        sweep(500);
        apply_reset();
        sweep(WORDS);
        check_val("init_done_restart", 64'(init_done), 64'(1));
        last_pop = '1;
        do_cycle(1'b1, 1'b0, 10'h155, '0, '0, 1'b1, acc);
        idle(3, 1'b1);
        check_val("rd_after_restart", last_pop, 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
